// File: rtl/iomem_gpio_if.sv
// iomem_gpio_if: picosoc iomem bus between the CPU (master) and a slave peripheral.
interface iomem_gpio_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master(output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave(input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_gpio.sv
// iomem_gpio: WIDTH-bit GPIO slave on the iomem bus with atomic set/clr/tgl and edge interrupts.
module iomem_gpio #(
  parameter int              WIDTH       = 8,
  parameter logic [7:0]      BASE_ADDR   = 8'h03,
  parameter int              SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT  = '0
) (
  input  logic             clk2,
  input  logic             resetn,
  iomem_gpio_if.slave      iomem,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] hist, in_s, rise_en, fall_en, status, ev, wm, wv, rsel, clr;
  logic [31:0] bm, wfull, rdata;
  logic [3:0]  idx;
  logic        ready, accept, wr, unused_ok;
  assign in_s   = sync[SYNC_STAGES-1];
  assign accept = iomem.valid && iomem.addr[31:24] == BASE_ADDR && !ready;
  assign wr     = accept && |iomem.wstrb;
  assign idx    = iomem.addr[5:2];
  assign bm     = {{8{iomem.wstrb[3]}}, {8{iomem.wstrb[2]}}, {8{iomem.wstrb[1]}}, {8{iomem.wstrb[0]}}};
  assign wfull  = iomem.wdata & bm;
  assign wm     = bm[WIDTH-1:0];
  assign wv     = wfull[WIDTH-1:0];
  assign ev     = (in_s & ~hist & rise_en) | (~in_s & hist & fall_en);
  assign clr    = (wr && idx == 4'd8) ? wv : '0;
  assign irq    = |status;
  assign iomem.ready = ready;
  assign iomem.rdata = rdata;
  assign unused_ok = ^{iomem.addr[23:6], iomem.addr[1:0], bm, wfull};
  // write-only and reserved offsets read back as zero
  assign rsel = idx == 4'd0 ? gpio_out :
                idx == 4'd1 ? gpio_oe  :
                idx == 4'd2 ? in_s     :
                idx == 4'd6 ? rise_en  :
                idx == 4'd7 ? fall_en  :
                idx == 4'd8 ? status   : '0;
  always_ff @(posedge clk2) begin
    if (!resetn) begin
      sync     <= '0;
      hist     <= '0;
      gpio_out <= RESET_OUT;
      gpio_oe  <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      ready    <= 1'b0;
      rdata    <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], gpio_in};
      hist   <= in_s;
      ready  <= accept;
      // new events are OR-ed in after the W1C mask so a coincident set wins
      status <= (status & ~clr) | ev;
      if (accept) rdata <= 32'(rsel);
      if (wr) begin
        gpio_out <= idx == 4'd0 ? (gpio_out & ~wm) | wv :
                    idx == 4'd3 ? gpio_out | wv :
                    idx == 4'd4 ? gpio_out & ~wv :
                    idx == 4'd5 ? gpio_out ^ wv : gpio_out;
        gpio_oe  <= idx == 4'd1 ? (gpio_oe & ~wm) | wv : gpio_oe;
        rise_en  <= idx == 4'd6 ? (rise_en & ~wm) | wv : rise_en;
        fall_en  <= idx == 4'd7 ? (fall_en & ~wm) | wv : fall_en;
      end
    end
  end
endmodule

// File: tb/tb_iomem_gpio.sv
// tb_iomem_gpio: directed register, interrupt, decode and reset checks for iomem_gpio.
module tb_iomem_gpio;
  localparam logic [31:0] BASE = 32'h0300_0000;
  logic clk2 = 1'b0;
  logic resetn;
  logic [7:0] gpio_in, gpio_out, gpio_oe;
  logic irq;
  logic [31:0] r, held;
  int total = 0;
  int fails = 0;
  iomem_gpio_if bus();
  iomem_gpio #(.WIDTH(8), .BASE_ADDR(8'h03), .SYNC_STAGES(2), .RESET_OUT(8'hA5)) dut (
    .clk2(clk2), .resetn(resetn), .iomem(bus.slave),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );
  always #5 clk2 = ~clk2;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk2);
    bus.valid = 1'b1; bus.addr = a; bus.wstrb = s; bus.wdata = d;
    @(posedge clk2); #1;
    chk("ready_hi", {31'b0, bus.ready}, 32'd1);
    rd = bus.rdata;
    @(negedge clk2);
    bus.valid = 1'b0; bus.wstrb = 4'h0;
    @(posedge clk2); #1;
    chk("ready_lo", {31'b0, bus.ready}, 32'd0);
  endtask
  initial begin
    resetn = 1'b0; gpio_in = 8'h00;
    bus.valid = 1'b0; bus.addr = '0; bus.wstrb = 4'h0; bus.wdata = '0;
    repeat (3) @(posedge clk2);
    @(negedge clk2); resetn = 1'b1;
    #1;
    chk("rst_out", {24'b0, gpio_out}, 32'hA5);
    chk("rst_oe", {24'b0, gpio_oe}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_ready", {31'b0, bus.ready}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    access(BASE + 32'h00, 4'h0, 32'h0, r);     chk("rd_out_reset", r, 32'h0000_00A5);
    access(BASE + 32'h04, 4'h0, 32'h0, r);     chk("rd_dir_reset", r, 32'h0);
    access(BASE + 32'h04, 4'b0001, 32'hFFFF_FFFF, r);
    chk("wr_dir_prev", r, 32'h0);
    chk("oe_ff", {24'b0, gpio_oe}, 32'hFF);
    access(BASE + 32'h04, 4'h0, 32'h0, r);     chk("rd_dir_ff", r, 32'h0000_00FF);
    access(BASE + 32'h04, 4'b0010, 32'h0, r);  chk("oe_lane1_only", {24'b0, gpio_oe}, 32'hFF);
    access(BASE + 32'h00, 4'hF, 32'h0F, r);
    chk("wr_out_prev", r, 32'hA5);
    chk("out_0f", {24'b0, gpio_out}, 32'h0F);
    access(BASE + 32'h0C, 4'hF, 32'h30, r);    chk("set", {24'b0, gpio_out}, 32'h3F);
    access(BASE + 32'h10, 4'hF, 32'h03, r);    chk("clr", {24'b0, gpio_out}, 32'h3C);
    access(BASE + 32'h14, 4'hF, 32'hFF, r);    chk("tgl", {24'b0, gpio_out}, 32'hC3);
    access(BASE + 32'h0C, 4'h0, 32'h0, r);     chk("rd_set", r, 32'h0);
    access(BASE + 32'h10, 4'h0, 32'h0, r);     chk("rd_clr", r, 32'h0);
    access(BASE + 32'h14, 4'h0, 32'h0, r);     chk("rd_tgl", r, 32'h0);
    access(BASE + 32'h08, 4'h0, 32'h0, r);     chk("rd_in_0", r, 32'h0);
    access(BASE + 32'h18, 4'hF, 32'h01, r);
    @(negedge clk2); gpio_in = 8'h01;
    @(posedge clk2); #1; chk("irq_e0", {31'b0, irq}, 32'h0);
    @(posedge clk2); #1; chk("irq_e1", {31'b0, irq}, 32'h0);
    @(posedge clk2); #1; chk("irq_e2", {31'b0, irq}, 32'h1);
    access(BASE + 32'h08, 4'h0, 32'h0, r);     chk("rd_in_1", r, 32'h01);
    access(BASE + 32'h20, 4'h0, 32'h0, r);     chk("status_set", r, 32'h01);
    @(negedge clk2); gpio_in = 8'h00;
    repeat (4) @(posedge clk2);
    access(BASE + 32'h20, 4'h0, 32'h0, r);     chk("fall_ignored", r, 32'h01);
    access(BASE + 32'h20, 4'hF, 32'h01, r);
    chk("w1c_prev", r, 32'h01);
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    @(negedge clk2); gpio_in = 8'h01;
    @(posedge clk2);
    @(negedge clk2);
    @(negedge clk2); bus.valid = 1'b1; bus.addr = BASE + 32'h20; bus.wstrb = 4'hF; bus.wdata = 32'h01;
    @(posedge clk2); #1;
    chk("race_ready", {31'b0, bus.ready}, 32'h1);
    chk("race_prev", bus.rdata, 32'h0);
    chk("race_irq", {31'b0, irq}, 32'h1);
    @(negedge clk2); bus.valid = 1'b0; bus.wstrb = 4'h0;
    @(posedge clk2); #1;
    chk("race_irq_hold", {31'b0, irq}, 32'h1);
    access(BASE + 32'h20, 4'hF, 32'h01, r);    chk("w1c2_irq", {31'b0, irq}, 32'h0);
    held = bus.rdata;
    @(negedge clk2); bus.valid = 1'b1; bus.addr = 32'h0200_000C; bus.wstrb = 4'hF; bus.wdata = 32'hFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk2); #1;
      chk("nodec_ready", {31'b0, bus.ready}, 32'h0);
    end
    chk("nodec_rdata", bus.rdata, held);
    chk("nodec_out", {24'b0, gpio_out}, 32'hC3);
    @(negedge clk2); bus.valid = 1'b0; bus.wstrb = 4'h0;
    access(BASE + 32'h30, 4'h0, 32'h0, r);     chk("rd_rsvd", r, 32'h0);
    access(BASE + 32'h30, 4'hF, 32'hFF, r);
    chk("wr_rsvd_out", {24'b0, gpio_out}, 32'hC3);
    chk("wr_rsvd_oe", {24'b0, gpio_oe}, 32'hFF);
    access(BASE + 32'h18, 4'h0, 32'h0, r);     chk("wr_rsvd_rise", r, 32'h01);
    @(negedge clk2);
    bus.valid = 1'b1; bus.addr = BASE + 32'h0C; bus.wstrb = 4'hF; bus.wdata = 32'hFF; resetn = 1'b0;
    @(posedge clk2); #1;
    chk("rstmid_ready", {31'b0, bus.ready}, 32'h0);
    chk("rstmid_out", {24'b0, gpio_out}, 32'hA5);
    chk("rstmid_oe", {24'b0, gpio_oe}, 32'h0);
    @(negedge clk2); bus.valid = 1'b0; bus.wstrb = 4'h0; resetn = 1'b1;
    @(posedge clk2); #1;
    chk("rstmid_ready2", {31'b0, bus.ready}, 32'h0);
    chk("rstmid_out2", {24'b0, gpio_out}, 32'hA5);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
